// File: rtl/cxapbasyncbridge_pkg.sv
// Shared encodings, payload widths and field positions for the APB async bridge.
package cxapbasyncbridge_pkg;

    localparam int FWD_W = 65;
    localparam int REV_W = 33;

    // Forward payload fields: {paddr, pwdata, pwrite}
    localparam int FWD_WRITE_BIT = 0;
    localparam int FWD_WDATA_LSB = 1;
    localparam int FWD_WDATA_MSB = 32;
    localparam int FWD_ADDR_LSB  = 33;
    localparam int FWD_ADDR_MSB  = 64;

    // Reverse payload fields: {prdata, pslverr}
    localparam int REV_ERR_BIT   = 0;
    localparam int REV_RDATA_LSB = 1;
    localparam int REV_RDATA_MSB = 32;

    typedef enum logic [1:0] {
        CXAPBAS_SLV_IDLE   = 2'b00,
        CXAPBAS_SLV_REQ    = 2'b01,
        CXAPBAS_SLV_RESP   = 2'b10,
        CXAPBAS_SLV_ACKLOW = 2'b11
    } slv_state_e;

    function automatic logic [FWD_W-1:0] pack_fwd(input logic [31:0] addr,
                                                   input logic [31:0] wdata,
                                                   input logic        write);
        return {addr, wdata, write};
    endfunction

endpackage

// File: rtl/cxapbasyncbridge_sync2.sv
// Two-flop synchroniser for signals crossing into the local clock domain.
module cxapbasyncbridge_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cxapbasyncbridge_slave_domain.sv
// APB3 completer side of the async bridge: turns each APB transfer into a
// four-phase req/ack exchange and returns the far-end response on preadys.
module cxapbasyncbridge_slave_domain
    import cxapbasyncbridge_pkg::*;
(
    input  logic             pclks,
    input  logic             presets,
    input  logic             pclkens,
    input  logic             pselS,
    input  logic             penables,
    input  logic             pwrites,
    input  logic [31:0]      paddrs,
    input  logic [31:0]      pwdatas,
    output logic [31:0]      prdatas,
    output logic             pslverrs,
    output logic             preadys,
    output logic             apbs_req_async,
    input  logic             apbs_ack_async,
    output logic [FWD_W-1:0] apbs_fwd_data_async,
    input  logic [REV_W-1:0] apbs_rev_data_async,
    output logic [1:0]       slv_state
);

    slv_state_e       state;
    logic             ack_sync;
    logic             setup;
    logic             req_q;
    logic             pend_q;
    logic [FWD_W-1:0] fwd_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    // Runs on every pclks edge, independent of pclkens.
    cxapbasyncbridge_sync2 #(.WIDTH(1)) u_ack_sync (
        .clk (pclks),
        .rst (presets),
        .d   (apbs_ack_async),
        .q   (ack_sync)
    );

    assign setup = pselS & ~penables & pclkens;

    always_ff @(posedge pclks or posedge presets) begin
        if (presets) begin
            state   <= CXAPBAS_SLV_IDLE;
            req_q   <= 1'b0;
            pend_q  <= 1'b0;
            fwd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (pclkens) begin
            case (state)
                CXAPBAS_SLV_IDLE: begin
                    if (setup) begin
                        fwd_q <= pack_fwd(paddrs, pwdatas, pwrites);
                        req_q <= 1'b1;
                        state <= CXAPBAS_SLV_REQ;
                    end
                end
                CXAPBAS_SLV_REQ: begin
                    if (ack_sync) begin
                        rdata_q <= apbs_rev_data_async[REV_RDATA_MSB:REV_RDATA_LSB];
                        err_q   <= apbs_rev_data_async[REV_ERR_BIT];
                        req_q   <= 1'b0;
                        state   <= CXAPBAS_SLV_RESP;
                    end
                end
                CXAPBAS_SLV_RESP: begin
                    state <= ack_sync ? CXAPBAS_SLV_ACKLOW : CXAPBAS_SLV_IDLE;
                end
                CXAPBAS_SLV_ACKLOW: begin
                    // A new request may only launch once the previous ack has dropped.
                    if (setup) fwd_q <= pack_fwd(paddrs, pwdatas, pwrites);
                    if (!ack_sync) begin
                        if (pend_q || setup) begin
                            req_q  <= 1'b1;
                            pend_q <= 1'b0;
                            state  <= CXAPBAS_SLV_REQ;
                        end else begin
                            state  <= CXAPBAS_SLV_IDLE;
                        end
                    end else if (setup) begin
                        pend_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign preadys             = (state == CXAPBAS_SLV_RESP);
    assign prdatas             = rdata_q;
    assign pslverrs            = err_q & preadys;
    assign apbs_req_async      = req_q;
    assign apbs_fwd_data_async = fwd_q;
    assign slv_state           = state;

endmodule

// File: tb/tb_cxapbasyncbridge_slave_domain.sv
// Bench for the slave-domain half of the APB async bridge, with a far-end responder.
module tb_cxapbasyncbridge_slave_domain;

    logic        pclks = 1'b0;
    logic        presets, pclkens, pselS, penables, pwrites;
    logic [31:0] paddrs, pwdatas, prdatas;
    logic        pslverrs, preadys, apbs_req_async, apbs_ack_async;
    logic [64:0] apbs_fwd_data_async;
    logic [32:0] apbs_rev_data_async;
    logic [1:0]  slv_state;

    cxapbasyncbridge_slave_domain dut (
        .pclks(pclks), .presets(presets), .pclkens(pclkens), .pselS(pselS),
        .penables(penables), .pwrites(pwrites), .paddrs(paddrs), .pwdatas(pwdatas),
        .prdatas(prdatas), .pslverrs(pslverrs), .preadys(preadys),
        .apbs_req_async(apbs_req_async), .apbs_ack_async(apbs_ack_async),
        .apbs_fwd_data_async(apbs_fwd_data_async),
        .apbs_rev_data_async(apbs_rev_data_async), .slv_state(slv_state)
    );

    always #5 pclks = ~pclks;

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0] fwd_exp[$];
    logic [32:0] rsp_q[$];

    // Far-end responder controls
    int          ack_delay  = 2;
    int          drop_delay = 1;
    logic [32:0] next_rev   = '0;
    logic        en_toggle  = 1'b0;
    logic        last_en;

    // Values observed by the driver right after a setup edge
    logic        req_after_setup;
    logic [64:0] fwd_after_setup;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        last_en = pclkens;
        @(posedge pclks);
        #1;
        if (en_toggle) pclkens = ~pclkens;
    endtask

    task automatic apb_xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                            output int cyc, output logic [31:0] rd, output logic er);
        logic rdy;
        logic done;
        pselS = 1'b1; penables = 1'b0; paddrs = a; pwdatas = d; pwrites = w;
        fwd_exp.push_back({a, d, w});
        do tick(); while (!last_en);
        req_after_setup = apbs_req_async;
        fwd_after_setup = apbs_fwd_data_async;
        penables = 1'b1;
        cyc = 0; done = 1'b0; rd = '0; er = 1'b0;
        while (!done && cyc < 200) begin
            rdy = preadys; rd = prdatas; er = pslverrs;
            tick();
            cyc++;
            if (rdy && last_en) done = 1'b1;
        end
        if (!done) check("xfer_timeout", 1'b0, 1'b1);
        pselS = 1'b0; penables = 1'b0;
    endtask

    // Far end: raise ack with the response some cycles after req, drop it after req falls.
    initial begin
        int fe_st;
        int fe_cnt;
        fe_st = 0; fe_cnt = 0;
        apbs_ack_async = 1'b0;
        apbs_rev_data_async = '0;
        forever begin
            @(posedge pclks);
            #1;
            if (presets) begin
                fe_st = 0; fe_cnt = 0; apbs_ack_async = 1'b0;
            end else begin
                case (fe_st)
                    0: if (apbs_req_async) begin fe_cnt = ack_delay; fe_st = 1; end
                    1: if (fe_cnt == 0) begin
                           apbs_rev_data_async = next_rev;
                           apbs_ack_async = 1'b1;
                           rsp_q.push_back(next_rev);
                           fe_st = 2;
                       end else fe_cnt--;
                    2: if (!apbs_req_async) begin fe_cnt = drop_delay; fe_st = 3; end
                    default: if (fe_cnt == 0) begin
                           apbs_ack_async = 1'b0;
                           apbs_rev_data_async = {$urandom, 1'($urandom_range(0, 1))};
                           fe_st = 0;
                       end else fe_cnt--;
                endcase
            end
        end
    end

    // Reference behaviour checked on every falling edge.
    initial begin
        logic        req_prev, rdy_prev, err_prev, en_prev, valid_prev;
        logic [64:0] fwd_prev;
        logic [31:0] rd_prev, last_rdata;
        logic [1:0]  st_prev;
        logic        h0, h1, h2;
        logic [64:0] e;
        logic [32:0] r;
        req_prev = 0; rdy_prev = 0; err_prev = 0; en_prev = 0; valid_prev = 0;
        fwd_prev = '0; rd_prev = '0; last_rdata = '0; st_prev = '0;
        h0 = 0; h1 = 0; h2 = 0;
        forever begin
            @(negedge pclks);
            if (presets) begin
                req_prev = 0; rdy_prev = 0; err_prev = 0; en_prev = 0; valid_prev = 0;
                fwd_prev = '0; rd_prev = '0; last_rdata = '0; st_prev = '0;
                h0 = 0; h1 = 0; h2 = 0;
                continue;
            end
            // h2 is the ack level the DUT saw through its synchroniser at the last edge
            if (apbs_req_async && !req_prev) begin
                check("req_rise_ack_sync_low", h2, 1'b0);
                check("req_rise_on_enabled_edge", en_prev, 1'b1);
                if (fwd_exp.size() == 0) check("req_without_setup", 1'b1, 1'b0);
                else begin
                    e = fwd_exp.pop_front();
                    check("fwd_payload", apbs_fwd_data_async, e);
                end
            end
            if (apbs_req_async && req_prev) check("fwd_stable_under_req", apbs_fwd_data_async, fwd_prev);
            if (preadys) check("req_low_while_ready", apbs_req_async, 1'b0);
            else         check("pslverr_outside_ready", pslverrs, 1'b0);
            if (preadys && !rdy_prev) begin
                if (rsp_q.size() == 0) check("ready_without_response", 1'b1, 1'b0);
                else begin
                    r = rsp_q.pop_front();
                    last_rdata = r[32:1];
                    check("pslverr_value", pslverrs, r[0]);
                end
            end
            check("prdata", prdatas, last_rdata);
            if (valid_prev && rdy_prev && en_prev) check("ready_one_enabled_cycle", preadys, 1'b0);
            if (valid_prev && !en_prev) begin
                check("hold_req", apbs_req_async, req_prev);
                check("hold_ready", preadys, rdy_prev);
                check("hold_err", pslverrs, err_prev);
                check("hold_rdata", prdatas, rd_prev);
                check("hold_fwd", apbs_fwd_data_async, fwd_prev);
                check("hold_state", slv_state, st_prev);
            end
            req_prev = apbs_req_async; rdy_prev = preadys; err_prev = pslverrs;
            fwd_prev = apbs_fwd_data_async; rd_prev = prdatas; st_prev = slv_state;
            h2 = h1; h1 = h0; h0 = apbs_ack_async;
            en_prev = pclkens; valid_prev = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        logic [31:0] rd;
        logic        er;
        presets = 1'b1; pclkens = 1'b1; pselS = 1'b0; penables = 1'b0; pwrites = 1'b0;
        paddrs = '0; pwdatas = '0;
        tick(); tick();
        check("reset_req", apbs_req_async, 1'b0);
        check("reset_ready", preadys, 1'b0);
        check("reset_err", pslverrs, 1'b0);
        check("reset_rdata", prdatas, 32'h0);
        check("reset_fwd", apbs_fwd_data_async, 65'h0);
        check("reset_state", slv_state, 2'b00);
        presets = 1'b0;
        tick(); tick();

        // Write, far end answers three cycles after seeing req
        ack_delay = 2; drop_delay = 1; next_rev = {32'hCAFE_0001, 1'b0};
        apb_xfer(32'h4000_0010, 32'hDEAD_BEEF, 1'b1, cyc, rd, er);
        check("wr_req_after_setup", req_after_setup, 1'b1);
        check("wr_fwd_literal", fwd_after_setup, 65'h0_8000_0021_BD5B_7DDF);
        check("wr_access_cycles", 32'(cyc), 32'd7);
        check("wr_pslverr", er, 1'b0);
        check("wr_prdata", rd, 32'hCAFE_0001);
        tick(); tick(); tick();

        // Read returning an error
        next_rev = {32'h1234_5678, 1'b1};
        apb_xfer(32'h0000_0100, 32'h0, 1'b0, cyc, rd, er);
        check("rd_prdata", rd, 32'h1234_5678);
        check("rd_pslverr", er, 1'b1);
        tick();
        check("rd_pslverr_after", pslverrs, 1'b0);
        tick(); tick(); tick();

        // Back-to-back: second setup lands while ack is still high
        ack_delay = 0; drop_delay = 6; next_rev = {32'hAAAA_0001, 1'b0};
        apb_xfer(32'h0000_0200, 32'h1111_1111, 1'b1, cyc, rd, er);
        next_rev = {32'hBBBB_0002, 1'b0};
        apb_xfer(32'h0000_0204, 32'h2222_2222, 1'b1, cyc, rd, er);
        check("b2b_req_held_at_setup", req_after_setup, 1'b0);
        check("b2b_second_prdata", rd, 32'hBBBB_0002);
        drop_delay = 1;
        repeat (10) tick();

        // Clock enable toggling through a transfer
        en_toggle = 1'b1; ack_delay = 1; next_rev = {32'h5A5A_A5A5, 1'b0};
        apb_xfer(32'h0000_0300, 32'h3333_3333, 1'b0, cyc, rd, er);
        check("ce_prdata", rd, 32'h5A5A_A5A5);
        en_toggle = 1'b0; pclkens = 1'b1;
        repeat (6) tick();

        // penables without a setup phase must not start anything
        pselS = 1'b1; penables = 1'b1;
        repeat (4) tick();
        check("enable_only_no_req", apbs_req_async, 1'b0);
        pselS = 1'b0; penables = 1'b0;
        tick();

        // Reset while waiting in REQ
        ack_delay = 10;
        pselS = 1'b1; penables = 1'b0; paddrs = 32'h0000_0400; pwdatas = 32'h4444_4444; pwrites = 1'b1;
        fwd_exp.push_back({32'h0000_0400, 32'h4444_4444, 1'b1});
        tick();
        penables = 1'b1;
        tick();
        check("rst_pre_req", apbs_req_async, 1'b1);
        check("rst_pre_state", slv_state, 2'b01);
        #3 presets = 1'b1;
        #1;
        check("rst_async_req", apbs_req_async, 1'b0);
        check("rst_async_ready", preadys, 1'b0);
        check("rst_async_err", pslverrs, 1'b0);
        check("rst_async_state", slv_state, 2'b00);
        pselS = 1'b0; penables = 1'b0;
        tick(); tick(); tick();
        fwd_exp.delete(); rsp_q.delete();
        presets = 1'b0;
        tick(); tick();

        // Random transfers exercising the handshake rules
        for (int i = 0; i < 24; i++) begin
            ack_delay  = $urandom_range(0, 4);
            drop_delay = $urandom_range(0, 5);
            next_rev   = {$urandom, 1'($urandom_range(0, 1))};
            en_toggle  = ($urandom_range(0, 3) == 0);
            apb_xfer($urandom, $urandom, 1'($urandom_range(0, 1)), cyc, rd, er);
            check("rand_prdata", rd, next_rev[32:1]);
            check("rand_pslverr", er, next_rev[0]);
            en_toggle = 1'b0; pclkens = 1'b1;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (12) tick();
        check("end_fwd_queue_empty", 32'(fwd_exp.size()), 32'd0);
        check("end_rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
